// File: rtl/tt_um_seq_divider_hhrb98_pkg.sv
// Shared constants for the sequential restoring divider: operand width, FSM
// encoding and the bit positions used on the bidirectional pins.
package tt_um_seq_divider_hhrb98_pkg;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CntW  = $clog2(WIDTH);

  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

  localparam int unsigned StartBit = 4;
  localparam int unsigned BusyBit  = 5;
  localparam int unsigned DoneBit  = 6;
  localparam int unsigned ErrBit   = 7;

  localparam logic [7:0] UioOe = 8'b1110_0000;

endpackage

// File: rtl/tt_um_seq_divider_hhrb98_if.sv
// Tiny Tapeout user pin bundle (everything except clk/rst_n) for the divider.
interface tt_um_seq_divider_hhrb98_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_seq_divider_hhrb98_div_restore_step.sv
// One restoring-division iteration: shift {R,Q} left, conditionally subtract D.
module tt_um_seq_divider_hhrb98_div_restore_step
  import tt_um_seq_divider_hhrb98_pkg::*;
(
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0] r_shift;
  logic [WIDTH:0] d_ext;

  assign r_shift = {r_i, q_i[WIDTH-1]};
  assign d_ext   = {1'b0, d_i};

  // R < D holds on entry, so the restored remainder always fits WIDTH bits.
  always_comb begin
    if (r_shift >= d_ext) begin
      r_o = WIDTH'(r_shift - d_ext);
      q_o = {q_i[WIDTH-2:0], 1'b1};
    end else begin
      r_o = r_shift[WIDTH-1:0];
      q_o = {q_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/tt_um_seq_divider_hhrb98.sv
// 8-by-4 sequential restoring divider with start/busy/done/err handshake on the
// bidirectional pins; result {remainder, quotient} is registered on uo_out.
module tt_um_seq_divider_hhrb98
  import tt_um_seq_divider_hhrb98_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  r_q, r_d, q_q, q_d, d_q, d_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        res_q, res_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              start_prev_q;
  logic              start_edge;
  logic [WIDTH-1:0]  step_r, step_q;
  logic [WIDTH-1:0]  divisor, dvd_hi, dvd_lo;
  logic              unused_uio;

  assign divisor    = uio_in[WIDTH-1:0];
  assign dvd_hi     = ui_in[7:4];
  assign dvd_lo     = ui_in[3:0];
  assign start_edge = uio_in[StartBit] & ~start_prev_q;
  assign unused_uio = ^uio_in[7:5];

  tt_um_seq_divider_hhrb98_div_restore_step u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (step_r),
    .q_o (step_q)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      StRun: begin
        r_d = step_r;
        q_d = step_q;
        if (cnt_q == '0) begin
          state_d = StDone;
          res_d   = {step_r, step_q};
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        if (start_edge) begin
          d_d    = divisor;
          r_d    = dvd_hi;
          q_d    = dvd_lo;
          done_d = 1'b0;
          err_d  = 1'b0;
          // Quotient would not fit in WIDTH bits (or D=0): flag and finish at once.
          if (divisor == '0 || dvd_hi >= divisor) begin
            state_d = StDone;
            err_d   = 1'b1;
            done_d  = 1'b1;
            res_d   = {dvd_lo, {WIDTH{1'b1}}};
          end else begin
            state_d = StRun;
            busy_d  = 1'b1;
            cnt_d   = CntW'(WIDTH - 1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      r_q          <= '0;
      q_q          <= '0;
      d_q          <= '0;
      cnt_q        <= '0;
      res_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      start_prev_q <= 1'b0;
    end else if (ena) begin
      state_q      <= state_d;
      r_q          <= r_d;
      q_q          <= q_d;
      d_q          <= d_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      start_prev_q <= uio_in[StartBit];
    end
  end

  assign uo_out  = res_q;
  assign uio_out = {err_q, done_q, busy_q, 5'b0_0000};
  assign uio_oe  = UioOe;

endmodule
